md_phase_sequencer: RTL

- Top-level timestep controller for the N_CELL-wide MD pipeline.
- Per timestep it runs three phases in order: phase 1 (force), phase 2 (velocity update) and phase 3 (position update).
- Per phase it issues a one-cycle ready pulse, then collects the per-cell done bits until every bit has been seen.
- After phase 3 it flips the cache double-buffer select and advances the step counter. It repeats for n_steps timesteps, with a watchdog on each phase.

---
 rtl/md_phase_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/md_phase_sequencer.sv
// md_phase_sequencer: per-timestep force/velocity/position phase controller with done-mask collection and watchdog.
module md_phase_sequencer #(
  parameter int N_CELL = 27,
  parameter int TS_W   = 32,
  parameter int WDOG_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TS_W-1:0]     n_steps,
  output logic                p1_ready,
  input  logic [N_CELL-1:0]   p1_done,
  output logic                p2_ready,
  input  logic [N_CELL-1:0]   p2_done,
  output logic                p3_ready,
  input  logic [2*N_CELL-1:0] p3_done,
  output logic                double_buffer,
  output logic [TS_W-1:0]     step_count,
  output logic                busy,
  output logic                run_done,
  output logic                timeout_err
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] P1_START = 4'd1;
  localparam logic [3:0] P1_WAIT  = 4'd2;
  localparam logic [3:0] P2_START = 4'd3;
  localparam logic [3:0] P2_WAIT  = 4'd4;
  localparam logic [3:0] P3_START = 4'd5;
  localparam logic [3:0] P3_WAIT  = 4'd6;
  localparam logic [3:0] SWAP     = 4'd7;
  localparam logic [3:0] FINISH   = 4'd8;

  logic [3:0]          state, state_nxt;
  logic [2*N_CELL-1:0] mask, cur_done, acc;
  logic [WDOG_W-1:0]   wdog, wdog_inc;
  logic [TS_W-1:0]     n_reg;
  logic                is_start, is_wait, full, expire;

  // Phases 1/2 only fill the low half of the shared mask; the upper half is forced complete.
  always_comb begin
    is_start  = state == P1_START || state == P2_START || state == P3_START;
    is_wait   = state == P1_WAIT || state == P2_WAIT || state == P3_WAIT;
    cur_done  = state == P1_WAIT ? {{N_CELL{1'b1}}, p1_done} :
                state == P2_WAIT ? {{N_CELL{1'b1}}, p2_done} : p3_done;
    acc       = mask | cur_done;
    full      = &acc;
    wdog_inc  = wdog + WDOG_W'(1);
    expire    = &wdog_inc;
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = n_steps == '0 ? FINISH : P1_START;
      P1_START: state_nxt = P1_WAIT;
      P1_WAIT:  state_nxt = full ? P2_START : expire ? FINISH : P1_WAIT;
      P2_START: state_nxt = P2_WAIT;
      P2_WAIT:  state_nxt = full ? P3_START : expire ? FINISH : P2_WAIT;
      P3_START: state_nxt = P3_WAIT;
      P3_WAIT:  state_nxt = full ? SWAP : expire ? FINISH : P3_WAIT;
      SWAP:     state_nxt = step_count + TS_W'(1) == n_reg ? FINISH : P1_START;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mask          <= '0;
      wdog          <= '0;
      n_reg         <= '0;
      step_count    <= '0;
      double_buffer <= 1'b0;
      timeout_err   <= 1'b0;
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      p3_ready      <= 1'b0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      p1_ready <= state_nxt == P1_START;
      p2_ready <= state_nxt == P2_START;
      p3_ready <= state_nxt == P3_START;
      busy     <= state_nxt != IDLE;
      run_done <= state_nxt == FINISH;
      if (state == IDLE && start) begin
        n_reg       <= n_steps;
        step_count  <= '0;
        timeout_err <= 1'b0;
      end
      if (is_start) begin
        mask <= '0;
        wdog <= '0;
      end
      if (is_wait) begin
        mask <= acc;
        wdog <= wdog_inc;
      end
      if (is_wait && !full && expire) timeout_err <= 1'b1;
      if (state == SWAP) begin
        double_buffer <= ~double_buffer;
        step_count    <= step_count + TS_W'(1);
      end
    end
  end
endmodule
